// File: rtl/data_break_ctrl_pkg.sv
// Shared types for the data-break controller: sequencer states, channel id and channel count.
package db_types_pkg;
  localparam int NUM_CH = 2;

  typedef enum logic [2:0] {
    dbIDLE,
    dbARB,
    dbWAIT_GNT,
    dbMEM,
    dbDONE
  } dbSTATE_t;

  typedef logic dbCH_t;
endpackage

// File: rtl/data_break_ctrl_if.sv
// Device, CPU-break and core-memory signals of the data-break controller.
// The controller masters this bundle; the device/CPU/memory side is the slave.
interface data_break_ctrl_if
  import db_types_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) ();
  logic                dev_req [0:NUM_CH-1];
  logic [0:NUM_CH-1]   dev_wr;
  logic [0:ADDR_W-1]   dev_addr0;
  logic [0:ADDR_W-1]   dev_addr1;
  logic [0:DATA_W-1]   dev_wdata0;
  logic [0:DATA_W-1]   dev_wdata1;
  logic [0:NUM_CH-1]   dev_done;
  logic [0:NUM_CH-1]   dev_err;
  logic [0:DATA_W-1]   dev_rdata;
  logic                cpu_brk_req;
  logic                cpu_brk_gnt;
  logic                break_in_prog;
  logic                mem_req;
  logic                mem_we;
  logic [0:ADDR_W-1]   mem_addr;
  logic [0:DATA_W-1]   mem_wdata;
  logic [0:DATA_W-1]   mem_rdata;
  logic                mem_ack;
  logic                clear;

  modport master (
    input  dev_req, dev_wr, dev_addr0, dev_addr1, dev_wdata0, dev_wdata1,
    input  cpu_brk_gnt, mem_rdata, mem_ack, clear,
    output dev_done, dev_err, dev_rdata, cpu_brk_req, break_in_prog,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output dev_req, dev_wr, dev_addr0, dev_addr1, dev_wdata0, dev_wdata1,
    output cpu_brk_gnt, mem_rdata, mem_ack, clear,
    input  dev_done, dev_err, dev_rdata, cpu_brk_req, break_in_prog,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_break_ctrl_arbiter.sv
// Combinational fixed-priority channel pick, ch0 (RK8E disk) over ch1; zero latency.
module db_arbiter
  import db_types_pkg::*;
(
  input  logic  i_req0,
  input  logic  i_req1,
  output logic  o_vld,
  output dbCH_t o_id
);
  assign o_vld = i_req0 | i_req1;
  assign o_id  = i_req0 ? 1'b0 : 1'b1;
endmodule

// File: rtl/data_break_ctrl.sv
// PDP-8 data-break sequencer: dev_req -> cpu_brk_req +2, gnt -> mem_req +1, mem_ack -> dev_done +1.
// Holds mem_req until mem_ack; optional abort after TIMEOUT_CYC cycles when DB_TIMEOUT_EN is defined.
module data_break_ctrl
  import db_types_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
`ifdef DB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  data_break_ctrl_if.master bus
);
  dbSTATE_t          r_state;
  dbCH_t             r_id;
  logic              r_brk_req;
  logic              r_bip;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_clr_pend;
  logic [0:ADDR_W-1] r_mem_addr;
  logic [0:DATA_W-1] r_mem_wdata;
  logic [0:DATA_W-1] r_rdata;
  logic [0:NUM_CH-1] r_done;
  logic              w_vld;
  dbCH_t             w_id;
  logic              w_kill;

`ifdef DB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  r_cnt;
  logic [0:NUM_CH-1] r_err;
  assign bus.dev_err = r_err;
`else
  assign bus.dev_err = '0;
`endif

  db_arbiter u_arb (
    .i_req0 (bus.dev_req[0]),
    .i_req1 (bus.dev_req[1]),
    .o_vld  (w_vld),
    .o_id   (w_id)
  );

  // A clear seen at any point of the memory cycle, including the ack cycle, cancels completion.
  assign w_kill = r_clr_pend | bus.clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= dbIDLE;
      r_id        <= 1'b0;
      r_brk_req   <= 1'b0;
      r_bip       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_done      <= '0;
`ifdef DB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= '0;
`endif
    end else begin
      r_done <= '0;
`ifdef DB_TIMEOUT_EN
      r_err  <= '0;
`endif
      case (r_state)
        dbIDLE: begin
          if (!bus.clear && w_vld) r_state <= dbARB;
        end
        dbARB: begin
          if (bus.clear || !w_vld) begin
            r_state <= dbIDLE;
          end else begin
            r_id        <= w_id;
            r_mem_we    <= bus.dev_wr[w_id];
            r_mem_addr  <= w_id ? bus.dev_addr1 : bus.dev_addr0;
            r_mem_wdata <= w_id ? bus.dev_wdata1 : bus.dev_wdata0;
            r_brk_req   <= 1'b1;
            r_state     <= dbWAIT_GNT;
          end
        end
        dbWAIT_GNT: begin
          if (bus.clear) begin
            r_brk_req <= 1'b0;
            r_state   <= dbIDLE;
          end else if (bus.cpu_brk_gnt) begin
            r_brk_req <= 1'b0;
            r_bip     <= 1'b1;
            r_mem_req <= 1'b1;
            r_state   <= dbMEM;
`ifdef DB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        dbMEM: begin
          if (bus.clear) r_clr_pend <= 1'b1;
          if (bus.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_clr_pend <= 1'b0;
            if (w_kill) begin
              r_bip   <= 1'b0;
              r_state <= dbIDLE;
            end else begin
              if (!r_mem_we) r_rdata <= bus.mem_rdata;
              r_done[r_id] <= 1'b1;
              r_state      <= dbDONE;
            end
          end
`ifdef DB_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            r_mem_req  <= 1'b0;
            r_clr_pend <= 1'b0;
            r_bip      <= 1'b0;
            if (!w_kill) r_err[r_id] <= 1'b1;
            r_state    <= dbIDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        dbDONE: begin
          r_bip   <= 1'b0;
          r_state <= dbIDLE;
        end
        default: r_state <= dbIDLE;
      endcase
    end
  end

  assign bus.dev_done      = r_done;
  assign bus.dev_rdata     = r_rdata;
  assign bus.cpu_brk_req   = r_brk_req;
  assign bus.break_in_prog = r_bip;
  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
endmodule
